apb_arbiter: RTL and testbench

//  Shares one downstream APB completer port between N_REQ upstream APB requesters,
//  e.g. the per-hart AHB-Lite-to-APB bridges feeding one peripheral segment.

---
 rtl/apb_arbiter.sv | 132 +++++++++++++
 tb/tb_apb_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB completer among N_REQ requesters; setup 1 cycle after grant, access the next.
// Non-granted requesters are held in APB wait states (pready=0); a downstream stall holds the grant indefinitely.
module apb_arbiter #(
  parameter int N_REQ   = 2,
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32,
  parameter int W_PC    = 32,
  localparam int GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         apbs_psel,
  input  logic [N_REQ-1:0]         apbs_penable,
  input  logic [N_REQ-1:0]         apbs_pwrite,
  input  logic [N_REQ*W_PADDR-1:0] apbs_paddr,
  input  logic [N_REQ*W_DATA-1:0]  apbs_pwdata,
  input  logic [N_REQ*W_DATA-1:0]  apbs_phartid,
  input  logic [N_REQ*W_PC-1:0]    apbs_pd_pc,
  output logic [N_REQ-1:0]         apbs_pready,
  output logic [W_DATA-1:0]        apbs_prdata,
  output logic [N_REQ-1:0]         apbs_pslverr,
  output logic                     apbm_psel,
  output logic                     apbm_penable,
  output logic                     apbm_pwrite,
  output logic [W_PADDR-1:0]       apbm_paddr,
  output logic [W_DATA-1:0]        apbm_pwdata,
  output logic [W_DATA-1:0]        apbm_phartid,
  output logic [W_PC-1:0]          apbm_pd_pc,
  input  logic                     apbm_pready,
  input  logic [W_DATA-1:0]        apbm_prdata,
  input  logic                     apbm_pslverr,
  output logic [GW-1:0]            grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  typedef struct packed {
    logic               pwrite;
    logic [W_PADDR-1:0] paddr;
    logic [W_DATA-1:0]  pwdata;
    logic [W_DATA-1:0]  phartid;
    logic [W_PC-1:0]    pd_pc;
  } req_t;

  state_t        state, state_nxt;
  logic [GW-1:0] last;
  logic [GW-1:0] cand;
  logic [GW-1:0] pick_idx;
  logic          pick_vld;
  req_t          sel_req;

  // penable only qualifies the upstream transfer phase; arbitration looks at psel alone
  logic unused_penable;
  assign unused_penable = ^apbs_penable;

  // Search starts one past the last grant so every waiting requester is reached within N_REQ-1 transfers
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = GW'((int'(last) + off) % N_REQ);
      if (!pick_vld && apbs_psel[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == GW'(i)) begin
        sel_req.pwrite  = apbs_pwrite[i];
        sel_req.paddr   = apbs_paddr[i*W_PADDR +: W_PADDR];
        sel_req.pwdata  = apbs_pwdata[i*W_DATA +: W_DATA];
        sel_req.phartid = apbs_phartid[i*W_DATA +: W_DATA];
        sel_req.pd_pc   = apbs_pd_pc[i*W_PC +: W_PC];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (pick_vld) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (apbm_pready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      apbm_psel    <= 1'b0;
      apbm_penable <= 1'b0;
      apbm_pwrite  <= 1'b0;
      apbm_paddr   <= '0;
      apbm_pwdata  <= '0;
      apbm_phartid <= '0;
      apbm_pd_pc   <= '0;
      grant_id     <= '0;
      last         <= GW'(N_REQ - 1);
    end else begin
      state        <= state_nxt;
      apbm_psel    <= (state_nxt != S_IDLE);
      apbm_penable <= (state_nxt == S_ACCESS);
      if (state == S_IDLE && pick_vld) begin
        grant_id     <= pick_idx;
        last         <= pick_idx;
        apbm_pwrite  <= sel_req.pwrite;
        apbm_paddr   <= sel_req.paddr;
        apbm_pwdata  <= sel_req.pwdata;
        apbm_phartid <= sel_req.phartid;
        apbm_pd_pc   <= sel_req.pd_pc;
      end
    end
  end

  always_comb begin
    apbs_pready  = '0;
    apbs_pslverr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      apbs_pready[k]  = (state == S_ACCESS) && (grant_id == GW'(k)) && apbm_pready;
      apbs_pslverr[k] = apbs_pready[k] & apbm_pslverr;
    end
  end

  assign apbs_prdata = apbm_prdata;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: cycle-vector table on a 2-requester instance, plus fairness/reset sequences and a 3-requester wrap check.
module tb_apb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 2-requester instance
  logic [1:0]  s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
  logic [31:0] s_paddr;
  logic [63:0] s_pwdata, s_phartid, s_pd_pc;
  logic [31:0] s_prdata;
  logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [15:0] m_paddr;
  logic [31:0] m_pwdata, m_phartid, m_pd_pc, m_prdata;
  logic        gid;

  apb_arbiter #(.N_REQ(2), .W_PADDR(16), .W_DATA(32), .W_PC(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .apbs_psel(s_psel), .apbs_penable(s_penable), .apbs_pwrite(s_pwrite),
    .apbs_paddr(s_paddr), .apbs_pwdata(s_pwdata), .apbs_phartid(s_phartid),
    .apbs_pd_pc(s_pd_pc), .apbs_pready(s_pready), .apbs_prdata(s_prdata),
    .apbs_pslverr(s_pslverr),
    .apbm_psel(m_psel), .apbm_penable(m_penable), .apbm_pwrite(m_pwrite),
    .apbm_paddr(m_paddr), .apbm_pwdata(m_pwdata), .apbm_phartid(m_phartid),
    .apbm_pd_pc(m_pd_pc), .apbm_pready(m_pready), .apbm_prdata(m_prdata),
    .apbm_pslverr(m_pslverr), .grant_id(gid)
  );

  // 3-requester instance for wrap-around
  logic [2:0]  t_psel, t_pready, t_pslverr;
  logic [31:0] t_prdata, t_pwdata, t_phartid, t_pd_pc;
  logic        t_psel_m, t_penable_m, t_pwrite_m;
  logic [15:0] t_paddr_m;
  logic [1:0]  t_gid;

  apb_arbiter #(.N_REQ(3), .W_PADDR(16), .W_DATA(32), .W_PC(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .apbs_psel(t_psel), .apbs_penable(3'b000), .apbs_pwrite(3'b000),
    .apbs_paddr(48'h0003_0002_0001), .apbs_pwdata(96'd0), .apbs_phartid(96'd0),
    .apbs_pd_pc(96'd0), .apbs_pready(t_pready), .apbs_prdata(t_prdata),
    .apbs_pslverr(t_pslverr),
    .apbm_psel(t_psel_m), .apbm_penable(t_penable_m), .apbm_pwrite(t_pwrite_m),
    .apbm_paddr(t_paddr_m), .apbm_pwdata(t_pwdata), .apbm_phartid(t_phartid),
    .apbm_pd_pc(t_pd_pc), .apbm_pready(1'b1), .apbm_prdata(32'd0),
    .apbm_pslverr(1'b0), .grant_id(t_gid)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  psel, pwrite;
    logic [15:0] a0, a1;
    logic [31:0] d0, d1;
    logic        mrdy, merr;
    logic [31:0] mrdata;
    logic        e_psel, e_pen, e_pwrite;
    logic [15:0] e_paddr;
    logic [31:0] e_pwdata;
    logic [1:0]  e_rdy, e_err;
    logic        e_gid;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  task automatic apply(input int i, input vec_t v);
    if (v.rst) begin
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
    end else #1;
    s_psel   = v.psel;
    s_pwrite = v.pwrite;
    s_paddr  = {v.a1, v.a0};
    s_pwdata = {v.d1, v.d0};
    m_pready = v.mrdy;
    m_pslverr = v.merr;
    m_prdata = v.mrdata;
    #1;
    chk($sformatf("v%0d.psel", i),    32'(m_psel),    32'(v.e_psel));
    chk($sformatf("v%0d.penable", i), 32'(m_penable), 32'(v.e_pen));
    chk($sformatf("v%0d.pwrite", i),  32'(m_pwrite),  32'(v.e_pwrite));
    chk($sformatf("v%0d.paddr", i),   32'(m_paddr),   32'(v.e_paddr));
    chk($sformatf("v%0d.pwdata", i),  m_pwdata,       v.e_pwdata);
    chk($sformatf("v%0d.pready", i),  32'(s_pready),  32'(v.e_rdy));
    chk($sformatf("v%0d.pslverr", i), 32'(s_pslverr), 32'(v.e_err));
    chk($sformatf("v%0d.grant", i),   32'(gid),       32'(v.e_gid));
    chk($sformatf("v%0d.prdata", i),  s_prdata,       v.mrdata);
    @(negedge clk);
  endtask

  initial begin
    int g2, g3, cyc;
    // rst psel pwrite a0 a1 d0 d1 mrdy merr mrdata | psel pen pwrite paddr pwdata rdy err gid
    // single requester read, psel dropped during access
    vecs[0]  = '{1'b1, 2'b10, 2'b00, 16'h0000, 16'h0010, 32'h0, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 2'b00, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 2'b10, 2'b00, 16'h0000, 16'h0010, 32'h0, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0, 2'b00, 2'b00, 1'b1};
    vecs[2]  = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0010, 32'h0, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h0, 2'b10, 2'b00, 1'b1};
    vecs[3]  = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0010, 32'h0, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 16'h0010, 32'h0, 2'b00, 2'b00, 1'b1};
    // simultaneous writes from reset
    vecs[4]  = '{1'b1, 2'b11, 2'b11, 16'h0100, 16'h0200, 32'h11, 32'h22, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 2'b00, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, 2'b11, 2'b11, 16'h0100, 16'h0200, 32'h11, 32'h22, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0100, 32'h11, 2'b00, 2'b00, 1'b0};
    vecs[6]  = '{1'b0, 2'b11, 2'b11, 16'h0100, 16'h0200, 32'h11, 32'h22, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 16'h0100, 32'h11, 2'b01, 2'b00, 1'b0};
    vecs[7]  = '{1'b0, 2'b10, 2'b11, 16'h0100, 16'h0200, 32'h11, 32'h22, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'h0100, 32'h11, 2'b00, 2'b00, 1'b0};
    vecs[8]  = '{1'b0, 2'b10, 2'b11, 16'h0100, 16'h0200, 32'h11, 32'h22, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0200, 32'h22, 2'b00, 2'b00, 1'b1};
    vecs[9]  = '{1'b0, 2'b10, 2'b11, 16'h0100, 16'h0200, 32'h11, 32'h22, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 16'h0200, 32'h22, 2'b10, 2'b00, 1'b1};
    vecs[10] = '{1'b0, 2'b00, 2'b00, 16'h0100, 16'h0200, 32'h11, 32'h22, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'h0200, 32'h22, 2'b00, 2'b00, 1'b1};
    // req1 read with 3 wait states and slverr, req0 waiting meanwhile
    vecs[11] = '{1'b0, 2'b10, 2'b00, 16'h0040, 16'h0030, 32'h0, 32'h0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b1, 16'h0200, 32'h22, 2'b00, 2'b00, 1'b1};
    vecs[12] = '{1'b0, 2'b11, 2'b00, 16'h0040, 16'h0030, 32'h0, 32'h0, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b0, 1'b0, 16'h0030, 32'h0, 2'b00, 2'b00, 1'b1};
    vecs[13] = '{1'b0, 2'b11, 2'b00, 16'h0040, 16'h0030, 32'h0, 32'h0, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b1, 1'b0, 16'h0030, 32'h0, 2'b00, 2'b00, 1'b1};
    vecs[14] = '{1'b0, 2'b11, 2'b00, 16'h0040, 16'h0030, 32'h0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b0, 16'h0030, 32'h0, 2'b00, 2'b00, 1'b1};
    vecs[15] = '{1'b0, 2'b11, 2'b00, 16'h0040, 16'h0030, 32'h0, 32'h0, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b1, 1'b0, 16'h0030, 32'h0, 2'b00, 2'b00, 1'b1};
    vecs[16] = '{1'b0, 2'b11, 2'b00, 16'h0040, 16'h0030, 32'h0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 16'h0030, 32'h0, 2'b10, 2'b10, 1'b1};
    vecs[17] = '{1'b0, 2'b01, 2'b00, 16'h0040, 16'h0030, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0030, 32'h0, 2'b00, 2'b00, 1'b1};
    vecs[18] = '{1'b0, 2'b01, 2'b00, 16'h0040, 16'h0030, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0040, 32'h0, 2'b00, 2'b00, 1'b0};
    vecs[19] = '{1'b0, 2'b01, 2'b00, 16'h0040, 16'h0030, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 16'h0040, 32'h0, 2'b01, 2'b00, 1'b0};
    vecs[20] = '{1'b0, 2'b00, 2'b00, 16'h0040, 16'h0030, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0040, 32'h0, 2'b00, 2'b00, 1'b0};

    s_psel = '0; s_penable = '0; s_pwrite = '0; s_paddr = '0;
    s_pwdata = '0; s_phartid = 64'h0000_0001_0000_0000; s_pd_pc = '0;
    m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = '0;
    t_psel = '0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) apply(i, vecs[i]);

    // Fairness: both instances with every requester asserting continuously
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    s_psel = 2'b11; t_psel = 3'b111; m_pready = 1'b1; m_pslverr = 1'b0;
    g2 = 0; g3 = 0; cyc = 0;
    while ((g2 < 4 || g3 < 4) && cyc < 60) begin
      #1;
      if (m_psel && !m_penable && g2 < 4) begin
        chk($sformatf("fair2.grant%0d", g2), 32'(gid), 32'(g2 % 2));
        g2++;
      end
      if (t_psel_m && !t_penable_m && g3 < 4) begin
        chk($sformatf("wrap3.grant%0d", g3), 32'(t_gid), 32'(g3 % 3));
        g3++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("fair.grants_seen", 32'(g2 + g3), 32'd8);
    s_psel = 2'b00; t_psel = 3'b000;

    // Reset in the middle of a stalled access
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    s_psel = 2'b10; m_pready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rstmid.access_pen", 32'(m_penable), 32'd1);
    chk("rstmid.access_gid", 32'(gid), 32'd1);
    @(negedge clk);
    #2;
    chk("rstmid.stall_pen", 32'(m_penable), 32'd1);
    chk("rstmid.stall_rdy", 32'(s_pready), 32'd0);
    m_pready = 1'b1;
    #1;
    chk("rstmid.pre_rdy", 32'(s_pready), 32'b10);
    rst_n = 1'b0;
    #1;
    chk("rstmid.psel", 32'(m_psel), 32'd0);
    chk("rstmid.penable", 32'(m_penable), 32'd0);
    chk("rstmid.gid", 32'(gid), 32'd0);
    chk("rstmid.rdy", 32'(s_pready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s_psel = 2'b11;
    @(negedge clk);
    #2;
    chk("rstmid.after_psel", 32'(m_psel), 32'd1);
    chk("rstmid.after_gid", 32'(gid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
